// File: rtl/seg7_pkg.sv
// Shared 7-segment glyph table and decoder, used by both the display driver
// and the capture side so encode and decode never drift apart.
package seg7_pkg;

  typedef logic [6:0] seg_t;

  typedef struct packed {
    logic       err;
    logic [3:0] digit;
  } entry_t;

  // bit0=a ... bit6=g, 1 = lit
  localparam seg_t SEG_BLANK = 7'h00;
  localparam seg_t SEG_0     = 7'h3F;
  localparam seg_t SEG_1     = 7'h06;
  localparam seg_t SEG_2     = 7'h5B;
  localparam seg_t SEG_3     = 7'h4F;
  localparam seg_t SEG_4     = 7'h66;
  localparam seg_t SEG_5     = 7'h6D;
  localparam seg_t SEG_6     = 7'h7D;
  localparam seg_t SEG_7     = 7'h07;
  localparam seg_t SEG_8     = 7'h7F;
  localparam seg_t SEG_9     = 7'h6F;
  localparam seg_t SEG_A     = 7'h77;
  localparam seg_t SEG_B     = 7'h7C;
  localparam seg_t SEG_C     = 7'h39;
  localparam seg_t SEG_D     = 7'h5E;
  localparam seg_t SEG_E     = 7'h79;
  localparam seg_t SEG_F     = 7'h71;

  // Blank decodes to a clean zero; callers never queue it.
  function automatic entry_t seg_decode(input seg_t s);
    entry_t e;
    e.err   = 1'b0;
    e.digit = 4'h0;
    case (s)
      SEG_BLANK: e.digit = 4'h0;
      SEG_0:     e.digit = 4'h0;
      SEG_1:     e.digit = 4'h1;
      SEG_2:     e.digit = 4'h2;
      SEG_3:     e.digit = 4'h3;
      SEG_4:     e.digit = 4'h4;
      SEG_5:     e.digit = 4'h5;
      SEG_6:     e.digit = 4'h6;
      SEG_7:     e.digit = 4'h7;
      SEG_8:     e.digit = 4'h8;
      SEG_9:     e.digit = 4'h9;
      SEG_A:     e.digit = 4'hA;
      SEG_B:     e.digit = 4'hB;
      SEG_C:     e.digit = 4'hC;
      SEG_D:     e.digit = 4'hD;
      SEG_E:     e.digit = 4'hE;
      SEG_F:     e.digit = 4'hF;
      default:   e.err   = 1'b1;
    endcase
    return e;
  endfunction

endpackage

// File: rtl/seg7_capture_if.sv
// Decoded-digit stream handshake: producer drives valid/digit/err, consumer drives ready.
interface seg7_capture_if;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_digit;
  logic       out_err;

  modport master (output out_valid, output out_digit, output out_err, input out_ready);
  modport slave  (input out_valid, input out_digit, input out_err, output out_ready);
endinterface

// File: rtl/seg7_fifo.sv
// First-word-fall-through FIFO of decoded entries; head is read straight from storage.
module seg7_fifo
  import seg7_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  entry_t                   din_i,
  input  logic                     pop_i,
  output entry_t                   dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);

  entry_t          mem_q [DEPTH];
  logic [AW-1:0]   wr_q, rd_q;
  logic [AW:0]     lvl_q;
  logic            do_push, do_pop;

  assign empty_o = (lvl_q == '0);
  assign full_o  = (lvl_q == (AW+1)'(DEPTH));

  // A full FIFO still takes a push when the head leaves on the same edge.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      lvl_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= din_i;
        wr_q        <= wr_q + 1'b1;
      end
      if (do_pop) rd_q <= rd_q + 1'b1;
      if (do_push && !do_pop)      lvl_q <= lvl_q + 1'b1;
      else if (do_pop && !do_push) lvl_q <= lvl_q - 1'b1;
    end
  end

  assign dout_o  = mem_q[rd_q];
  assign level_o = lvl_q;

endmodule

// File: rtl/seg7_capture.sv
// Watches the segment bus, accepts each glyph once it has settled, decodes it
// and queues the result for a valid/ready consumer.
module seg7_capture
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  seg_t                          seg_in,
  seg7_capture_if.master                dout,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   level
);

  localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES - 1);

  seg_t       s_q;
  logic [7:0] cnt_q, cnt_d;
  logic       armed_q, armed_d;
  logic       ovf_q, ovf_d;
  logic       changed, accept, pop, push;
  logic       full, empty;
  entry_t     head;

  assign changed = (seg_in != s_q);
  // armed gives exactly one entry per settled glyph; blank only re-arms.
  assign accept  = !changed && (cnt_q == CNT_MAX) && armed_q && (s_q != SEG_BLANK);
  assign pop     = dout.out_valid & dout.out_ready;
  assign push    = accept & (~full | pop);

  always_comb begin
    cnt_d   = cnt_q;
    armed_d = armed_q;
    ovf_d   = ovf_q;
    if (changed) begin
      cnt_d   = '0;
      armed_d = 1'b1;
    end else begin
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + 8'd1;
      if (accept)           armed_d = 1'b0;
    end
    if (accept && full && !pop) ovf_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_q     <= SEG_BLANK;
      cnt_q   <= '0;
      armed_q <= 1'b1;
      ovf_q   <= 1'b0;
    end else begin
      s_q     <= seg_in;
      cnt_q   <= cnt_d;
      armed_q <= armed_d;
      ovf_q   <= ovf_d;
    end
  end

  seg7_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .din_i   (seg_decode(s_q)),
    .pop_i   (dout.out_ready),
    .dout_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .level_o (level)
  );

  assign dout.out_valid = ~empty;
  assign dout.out_digit = head.digit;
  assign dout.out_err   = head.err;
  assign overflow       = ovf_q;

endmodule

// File: tb/tb_seg7_capture.sv
// Randomised bench for seg7_capture: a run-length model of the segment bus feeds a
// scoreboard queue that a negedge monitor drains on every handshake.
module tb_seg7_capture;
  import seg7_pkg::*;

  localparam int SC    = 4;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [6:0] seg_in;
  logic       overflow;
  logic [2:0] level;

  seg7_capture_if dout();

  seg7_capture #(.STABLE_CYCLES(SC), .FIFO_DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .seg_in   (seg_in),
    .dout     (dout),
    .overflow (overflow),
    .level    (level)
  );

  always #5 clk = ~clk;

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [4:0] sb [$];
  int         mdl_lvl;
  bit         mdl_ovf;
  logic [6:0] prev_seg;
  int         run;

  logic [6:0] glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  function automatic logic [4:0] ref_entry(input logic [6:0] s);
    for (int i = 0; i < 16; i++)
      if (glyph[i] == s) return {1'b0, 4'(i)};
    return 5'b1_0000;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    sb.delete();
    mdl_lvl  = 0;
    mdl_ovf  = 0;
    prev_seg = 7'h00;
    run      = 0;
  endtask

  // One clock: a glyph held for SC+1 sampling edges is accepted on the last of them.
  task automatic step(input logic [6:0] s, input bit rdy);
    bit pop_m, acc;
    seg_in         = s;
    dout.out_ready = rdy;
    @(posedge clk);
    pop_m = rdy && (mdl_lvl > 0);
    if (s != prev_seg) run = 1;
    else               run++;
    prev_seg = s;
    acc = (run == SC + 1) && (s != 7'h00);
    if (acc) begin
      if (mdl_lvl < DEPTH || pop_m) begin
        sb.push_back(ref_entry(s));
        mdl_lvl++;
      end else begin
        mdl_ovf = 1;
      end
    end
    if (pop_m) mdl_lvl--;
    #1;
  endtask

  task automatic do_reset(input logic [6:0] s);
    seg_in = s;
    rst    = 1'b1;
    model_reset();
    #1;
    check("rst_valid",    dout.out_valid, 0);
    check("rst_level",    level,          0);
    check("rst_overflow", overflow,       0);
    check("rst_digit",    dout.out_digit, 0);
    check("rst_err",      dout.out_err,   0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      check("level",    level,          mdl_lvl);
      check("overflow", overflow,       mdl_ovf);
      check("valid",    dout.out_valid, mdl_lvl > 0);
      if (dout.out_valid && dout.out_ready) begin
        check("sb_nonempty", sb.size() > 0, 1);
        if (sb.size() > 0) check("head", {dout.out_err, dout.out_digit}, sb.pop_front());
      end
    end
  end

  initial begin
    seg_in         = 7'h00;
    dout.out_ready = 1'b0;
    model_reset();
    #2;

    // reset with a glyph already on the bus, then first-entry latency
    do_reset(7'h3F);
    repeat (SC) step(7'h3F, 0);
    check("latency_early", dout.out_valid, 0);
    step(7'h3F, 0);
    check("latency_valid", dout.out_valid, 1);
    check("latency_head", {dout.out_err, dout.out_digit}, 0);
    repeat (6) step(7'h3F, 0);
    check("single_entry", level, 1);
    step(7'h3F, 1);
    step(7'h3F, 0);

    // glitch rejection
    repeat (3) step(7'h06, 1);
    repeat (SC + 3) step(7'h5B, 1);

    // sweep 0..F separated by blanks
    for (int d = 0; d < 16; d++) begin
      repeat (SC + 1 + $urandom_range(0, 2)) step(glyph[d], 1);
      repeat ($urandom_range(1, 3)) step(7'h00, 1);
    end

    // held repeat, then an unrecognised pattern
    repeat (SC + 3) step(7'h6D, 1);
    repeat (SC + 3) step(7'h6D, 1);
    repeat (SC + 3) step(7'h01, 1);
    repeat (4) step(7'h00, 1);

    // overflow: five glyphs into a depth-4 FIFO with the consumer stalled
    for (int i = 0; i < 5; i++) begin
      repeat (SC + 1) step(glyph[i + 1], 0);
      step(7'h00, 0);
    end
    check("ovf_level", level, 4);
    check("ovf_flag", overflow, 1);
    check("ovf_head", {dout.out_err, dout.out_digit}, 1);
    repeat (SC) step(glyph[7], 0);
    step(glyph[7], 1);
    check("ovf_pop_level", level, 4);
    check("ovf_pop_flag", overflow, 1);
    repeat (8) step(7'h00, 1);

    // mid-stream reset with two entries queued
    repeat (SC + 1) step(glyph[10], 0);
    step(7'h00, 0);
    repeat (SC + 1) step(glyph[12], 0);
    check("mid_level", level, 2);
    do_reset(glyph[12]);
    repeat (SC + 1) step(glyph[12], 0);
    check("mid_reemit", level, 1);
    repeat (SC + 3) step(glyph[12], 1);

    // random runs with varying consumer pressure
    for (int r = 0; r < 150; r++) begin
      logic [6:0] p;
      int         sel, len, bias;
      sel  = $urandom_range(0, 9);
      if (sel < 7)       p = glyph[$urandom_range(0, 15)];
      else if (sel == 7) p = 7'h00;
      else               p = 7'($urandom);
      len  = $urandom_range(1, SC + 4);
      bias = $urandom_range(0, 4);
      for (int c = 0; c < len; c++) step(p, $urandom_range(0, 3) < bias);
    end

    repeat (DEPTH * 2 + 2) step(7'h00, 1);
    check("sb_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
